// File: rtl/i2c_multi_channel_ctrl_if.sv
// Byte-level I2C receiver side and coefficient-store side of the multi-channel loader.
// The width parameters must match the ones given to the controller.
interface i2c_multi_channel_ctrl_if #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned NTAPS       = 8,
   parameter int unsigned COEFF_BYTES = 2
);
   localparam int unsigned NBYTES = NTAPS * COEFF_BYTES;
   localparam int unsigned AW     = $clog2(NBYTES);
   localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1;

   logic [7:0]     i2c_byte_in;
   logic           i2c_valid_in;
   logic           i2c_start_in;
   logic           i2c_stop_in;
   logic           ack_out;
   logic [7:0]     coeff_byte_out;
   logic [AW-1:0]  coeff_addr_out;
   logic [CHW-1:0] coeff_ch_out;
   logic           coeff_we_out;
   logic [NCH-1:0] load_en_out;
   logic [NCH-1:0] filter_en_out;

   modport slave (
      input  i2c_byte_in, i2c_valid_in, i2c_start_in, i2c_stop_in,
      output ack_out, coeff_byte_out, coeff_addr_out, coeff_ch_out,
      output coeff_we_out, load_en_out, filter_en_out
   );

   modport master (
      output i2c_byte_in, i2c_valid_in, i2c_start_in, i2c_stop_in,
      input  ack_out, coeff_byte_out, coeff_addr_out, coeff_ch_out,
      input  coeff_we_out, load_en_out, filter_en_out
   );
endinterface

// File: rtl/i2c_multi_channel_ctrl.sv
// Decodes I2C write transactions into per-channel coefficient-store writes,
// load strobes and filter enable/disable commands for NCH filter channels.
module i2c_multi_channel_ctrl #(
   parameter logic [6:0]  I2C_ADDR    = 7'h50,
   parameter int unsigned NCH         = 4,
   parameter int unsigned NTAPS       = 8,
   parameter int unsigned COEFF_BYTES = 2
) (
   input logic                  clk,
   input logic                  rst,
   i2c_multi_channel_ctrl_if.slave bus
);
   localparam int unsigned NBYTES = NTAPS * COEFF_BYTES;
   localparam int unsigned AW     = $clog2(NBYTES);
   localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [6:0]    NCH_W    = 7'(NCH);
   localparam logic [AW-1:0] LAST_IDX = AW'(NBYTES - 1);

   typedef enum logic [2:0] {IDLE, HEADER, CMD, DATA, DONE, IGNORE} state_t;

   state_t         state_q, state_d;
   logic           valid_q;
   logic [AW-1:0]  cnt_q;
   logic [CHW-1:0] ch_q;
   logic           load_pend_q;

   logic           accept_c, abort_c;
   logic           ack_c, we_c, fin_c, fen_set_c, fen_clr_c, cnt_clr_c, ch_ld_c;
   logic [1:0]     op_c;
   logic [NCH-1:0] cmd_mask_c, ch_mask_c;

   assign accept_c   = bus.i2c_valid_in && !valid_q;
   assign abort_c    = bus.i2c_stop_in || bus.i2c_start_in;
   assign op_c       = bus.i2c_byte_in[7:6];
   assign cmd_mask_c = NCH'(1) << bus.i2c_byte_in[5:0];
   assign ch_mask_c  = NCH'(1) << ch_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and per-byte decisions; stop beats start beats byte accept
   always_comb begin
      state_d   = state_q;
      ack_c     = 1'b0;
      we_c      = 1'b0;
      fin_c     = 1'b0;
      fen_set_c = 1'b0;
      fen_clr_c = 1'b0;
      cnt_clr_c = 1'b0;
      ch_ld_c   = 1'b0;
      if (bus.i2c_stop_in) begin
         state_d = IDLE;
      end else if (bus.i2c_start_in) begin
         state_d = HEADER;
      end else if (accept_c) begin
         case (state_q)
            HEADER: begin
               if (bus.i2c_byte_in[7:1] == I2C_ADDR && !bus.i2c_byte_in[0]) begin
                  ack_c   = 1'b1;
                  state_d = CMD;
               end else begin
                  state_d = IGNORE;
               end
            end
            CMD: begin
               if ({1'b0, bus.i2c_byte_in[5:0]} >= NCH_W || op_c == 2'b11) begin
                  state_d = IGNORE;
               end else begin
                  ack_c   = 1'b1;
                  ch_ld_c = 1'b1;
                  case (op_c)
                     2'b00: begin
                        fen_clr_c = 1'b1;
                        cnt_clr_c = 1'b1;
                        state_d   = DATA;
                     end
                     2'b01: begin
                        fen_set_c = 1'b1;
                        state_d   = DONE;
                     end
                     default: begin
                        fen_clr_c = 1'b1;
                        state_d   = DONE;
                     end
                  endcase
               end
            end
            DATA: begin
               ack_c = 1'b1;
               we_c  = 1'b1;
               if (cnt_q == LAST_IDX) begin
                  fin_c   = 1'b1;
                  state_d = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Byte tracking, ACK drive and coefficient write path
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q            <= 1'b0;
         cnt_q              <= '0;
         ch_q               <= '0;
         load_pend_q        <= 1'b0;
         bus.ack_out        <= 1'b1;
         bus.coeff_we_out   <= 1'b0;
         bus.coeff_byte_out <= '0;
         bus.coeff_addr_out <= '0;
         bus.coeff_ch_out   <= '0;
         bus.load_en_out    <= '0;
      end else begin
         valid_q          <= bus.i2c_valid_in;
         load_pend_q      <= fin_c;
         bus.coeff_we_out <= we_c;
         bus.load_en_out  <= load_pend_q ? ch_mask_c : '0;

         if (abort_c)           bus.ack_out <= 1'b1;
         else if (ack_c)        bus.ack_out <= 1'b0;
         else if (!bus.i2c_valid_in) bus.ack_out <= 1'b1;

         if (ch_ld_c) ch_q <= CHW'(bus.i2c_byte_in[5:0]);

         if (abort_c || cnt_clr_c)   cnt_q <= '0;
         else if (we_c && !fin_c)    cnt_q <= cnt_q + AW'(1);

         if (we_c) begin
            bus.coeff_byte_out <= bus.i2c_byte_in;
            bus.coeff_addr_out <= cnt_q;
            bus.coeff_ch_out   <= ch_q;
         end
      end
   end

   // Filter enables move only on commands and on load completion
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.filter_en_out <= '0;
      end else begin
         if (fen_set_c)   bus.filter_en_out <= bus.filter_en_out | cmd_mask_c;
         if (fen_clr_c)   bus.filter_en_out <= bus.filter_en_out & ~cmd_mask_c;
         if (load_pend_q) bus.filter_en_out <= bus.filter_en_out | ch_mask_c;
      end
   end
endmodule
